// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock divider / enable generator.
//
// Each channel divides CLK_IN by a runtime-programmable ratio D and produces
// a divided clock (high ceil(E/2), low floor(E/2) cycles, E = max(D,1)) plus
// a one-cycle TICK at the start of every period.  New ratios are written
// into a per-channel shadow register and only take effect at a period
// boundary (wrap, SYNC, channel start, or while the channel is disabled),
// so the divided clock never glitches.
//
// Ports:
//   CLK_IN    system clock, rising edge
//   RST       asynchronous active-high reset
//   EN        per-channel run enable
//   SYNC      one-cycle pulse, restarts every enabled channel at cnt=0
//   LOAD      one-cycle shadow-register write strobe
//   LOAD_SEL  target channel for LOAD (values >= NCH are ignored)
//   DIV_IN    new divide ratio
//   CLK_OUT   divided clock per channel (registered)
//   TICK      one-cycle pulse per period (registered)
//   PENDING   shadow ratio waiting for the next boundary

// One divider channel.
module clk_div_multi_lane #(
   parameter int WIDTH   = 10,
   parameter int DEF_DIV = 2
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             en,
   input  logic             sync,
   input  logic             ld,
   input  logic [WIDTH-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   logic [WIDTH-1:0] cnt, dact, dsh;
   logic             run;       // channel was enabled at the previous edge
   logic [WIDTH-1:0] e_cur, e_nx, dact_nx, cnt_nx;
   logic [WIDTH:0]   half_nx;
   logic             bnd;

   always_comb begin
      e_cur   = (dact == '0) ? WIDTH'(1) : dact;
      // A boundary is any edge where the counter restarts at 0: disabled,
      // first enabled edge, SYNC, or natural wrap.
      bnd     = ~en | ~run | sync | (cnt == e_cur - WIDTH'(1));
      cnt_nx  = bnd ? '0 : cnt + WIDTH'(1);
      // The ratio applied at this boundary already governs the new period,
      // so the output compare uses the next-state ratio.
      dact_nx = (bnd && pending) ? dsh : dact;
      e_nx    = (dact_nx == '0) ? WIDTH'(1) : dact_nx;
      // One extra bit keeps E+1 from overflowing at E = 2^WIDTH-1.
      half_nx = ({1'b0, e_nx} + (WIDTH+1)'(1)) >> 1;
   end

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         run     <= 1'b0;
         dact    <= WIDTH'(DEF_DIV);
         dsh     <= WIDTH'(DEF_DIV);
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         run     <= en;
         dact    <= dact_nx;
         if (ld) dsh <= div_in;
         // A write landing on a boundary stays pending for the next one.
         pending <= ld | (pending & ~bnd);
         clk_out <= en & ({1'b0, cnt_nx} < half_nx);
         tick    <= en & (cnt_nx == '0);
      end
   end

endmodule

module clk_div_multi #(
   parameter int NCH     = 4,
   parameter int WIDTH   = 10,
   parameter int DEF_DIV = 2,
   parameter int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic [NCH-1:0]   EN,
   input  logic             SYNC,
   input  logic             LOAD,
   input  logic [SELW-1:0]  LOAD_SEL,
   input  logic [WIDTH-1:0] DIV_IN,
   output logic [NCH-1:0]   CLK_OUT,
   output logic [NCH-1:0]   TICK,
   output logic [NCH-1:0]   PENDING
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      // Out-of-range selects match no channel, so the write is dropped.
      logic ld;
      assign ld = LOAD & (LOAD_SEL == SELW'(i));

      clk_div_multi_lane #(
         .WIDTH   (WIDTH),
         .DEF_DIV (DEF_DIV)
      ) u_lane (
         .CLK_IN  (CLK_IN),
         .RST     (RST),
         .en      (EN[i]),
         .sync    (SYNC),
         .ld      (ld),
         .div_in  (DIV_IN),
         .clk_out (CLK_OUT[i]),
         .tick    (TICK[i]),
         .pending (PENDING[i])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios with constant expectations
// plus a per-channel behavioural model checked every cycle, and a random run.
module tb_clk_div_multi;

   localparam int NCH = 3, WIDTH = 10, DEF_DIV = 2, SELW = 2;

   logic             CLK_IN = 1'b0;
   logic             RST = 1'b1;
   logic [NCH-1:0]   EN = '0;
   logic             SYNC = 1'b0, LOAD = 1'b0;
   logic [SELW-1:0]  LOAD_SEL = '0;
   logic [WIDTH-1:0] DIV_IN = '0;
   logic [NCH-1:0]   CLK_OUT, TICK, PENDING;

   int n_chk = 0, n_fail = 0;

   clk_div_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
      .CLK_IN(CLK_IN), .RST(RST), .EN(EN), .SYNC(SYNC), .LOAD(LOAD),
      .LOAD_SEL(LOAD_SEL), .DIV_IN(DIV_IN),
      .CLK_OUT(CLK_OUT), .TICK(TICK), .PENDING(PENDING));

   always #5 CLK_IN = ~CLK_IN;

   // Model: each channel is a position within a period of length E.
   int pos [NCH], rdact [NCH], rdsh [NCH];
   bit rpend [NCH], rrun [NCH];
   logic [NCH-1:0] m_clk = '0, m_tick = '0, m_pend = '0;
   int me; bit mb;

   always @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         for (int c = 0; c < NCH; c++) begin
            pos[c] = 0; rdact[c] = DEF_DIV; rdsh[c] = DEF_DIV;
            rpend[c] = 0; rrun[c] = 0;
         end
         m_clk = '0; m_tick = '0; m_pend = '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            me = (rdact[c] < 1) ? 1 : rdact[c];
            if (!EN[c] || !rrun[c] || SYNC || pos[c] == me - 1) begin
               mb = 1; pos[c] = 0;
            end else begin
               mb = 0; pos[c] = pos[c] + 1;
            end
            rrun[c] = EN[c];
            if (mb && rpend[c]) begin rdact[c] = rdsh[c]; rpend[c] = 0; end
            if (LOAD && int'(LOAD_SEL) == c) begin rdsh[c] = int'(DIV_IN); rpend[c] = 1; end
            me = (rdact[c] < 1) ? 1 : rdact[c];
            m_tick[c] = EN[c] && pos[c] == 0;
            m_clk[c]  = EN[c] && pos[c] < (me + 1) / 2;
            m_pend[c] = rpend[c];
         end
      end
   end

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK_IN);
      n_chk++;
      if ({CLK_OUT, TICK, PENDING} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0", {CLK_OUT, TICK, PENDING});
      end
      RST = 1'b0;
      @(negedge CLK_IN);
      n_chk++;
      if ({CLK_OUT, TICK, PENDING} !== '0) begin
         n_fail++; $display("FAIL reset_idle: got %b expected 0", {CLK_OUT, TICK, PENDING});
      end
   endtask

   task automatic test_div2();
      EN = 3'b001;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT !== {2'b00, (k % 2) == 0} || TICK !== {2'b00, (k % 2) == 0}) begin
            n_fail++; $display("FAIL div2 k=%0d: clk %b tick %b expected %b", k, CLK_OUT, TICK, {2'b00, (k % 2) == 0});
         end
         n_chk++;
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_fail++; $display("FAIL div2_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
   endtask

   task automatic test_div5();
      LOAD = 1'b1; LOAD_SEL = 2'd1; DIV_IN = 10'd5;
      @(negedge CLK_IN);
      LOAD = 1'b0;
      n_chk++;
      if (PENDING[1] !== 1'b1) begin
         n_fail++; $display("FAIL div5_pending_set: got %b expected 1", PENDING[1]);
      end
      EN[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT[1] !== ((k % 5) < 3) || TICK[1] !== ((k % 5) == 0) || PENDING[1] !== 1'b0) begin
            n_fail++; $display("FAIL div5 k=%0d: clk %b tick %b pend %b", k, CLK_OUT[1], TICK[1], PENDING[1]);
         end
         n_chk++;
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_fail++; $display("FAIL div5_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
   endtask

   task automatic test_reload();
      // Put ch0 at D=4 by loading while disabled.
      EN[0] = 1'b0; LOAD = 1'b1; LOAD_SEL = 2'd0; DIV_IN = 10'd4;
      @(negedge CLK_IN);
      LOAD = 1'b0;
      @(negedge CLK_IN);
      EN[0] = 1'b1;
      @(negedge CLK_IN);  // cnt 0
      @(negedge CLK_IN);  // cnt 1
      LOAD = 1'b1; DIV_IN = 10'd7;
      for (int k = 2; k < 4; k++) begin
         @(negedge CLK_IN);
         LOAD = 1'b0;
         n_chk++;
         if (PENDING[0] !== 1'b1 || CLK_OUT[0] !== 1'b0) begin
            n_fail++; $display("FAIL reload_old_tail cnt=%0d: pend %b clk %b expected 1/0", k, PENDING[0], CLK_OUT[0]);
         end
      end
      for (int k = 0; k < 7; k++) begin
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT[0] !== (k < 4) || TICK[0] !== (k == 0) || PENDING[0] !== 1'b0) begin
            n_fail++; $display("FAIL reload_new k=%0d: clk %b tick %b pend %b", k, CLK_OUT[0], TICK[0], PENDING[0]);
         end
         n_chk++;
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_fail++; $display("FAIL reload_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
   endtask

   // Entered with ch0 at the last cycle of a D=7 period.
   task automatic test_load_on_wrap();
      LOAD = 1'b1; LOAD_SEL = 2'd0; DIV_IN = 10'd3;
      for (int k = 0; k < 7; k++) begin
         @(negedge CLK_IN);
         LOAD = 1'b0;
         n_chk++;
         if (CLK_OUT[0] !== (k < 4) || TICK[0] !== (k == 0) || PENDING[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrapload_old k=%0d: clk %b tick %b pend %b", k, CLK_OUT[0], TICK[0], PENDING[0]);
         end
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT[0] !== ((k % 3) < 2) || TICK[0] !== ((k % 3) == 0) || PENDING[0] !== 1'b0) begin
            n_fail++; $display("FAIL wrapload_new k=%0d: clk %b tick %b pend %b", k, CLK_OUT[0], TICK[0], PENDING[0]);
         end
      end
      // Out-of-range select is dropped.
      LOAD = 1'b1; LOAD_SEL = 2'd3; DIV_IN = 10'd9;
      @(negedge CLK_IN);
      LOAD = 1'b0;
      n_chk++;
      if (PENDING !== 3'b000) begin
         n_fail++; $display("FAIL bad_sel_ignored: pend %b expected 000", PENDING);
      end
   endtask

   task automatic test_sync();
      LOAD = 1'b1; LOAD_SEL = 2'd1; DIV_IN = 10'd6;
      @(negedge CLK_IN);
      LOAD = 1'b0;
      repeat (8) @(negedge CLK_IN);
      n_chk++;
      if (PENDING[1] !== 1'b0) begin
         n_fail++; $display("FAIL sync_preload: pend %b expected 0", PENDING[1]);
      end
      SYNC = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK_IN);
         SYNC = 1'b0;
         n_chk++;
         if (TICK[1:0] !== {(k % 6) == 0, (k % 3) == 0}) begin
            n_fail++; $display("FAIL sync_ticks k=%0d: got %b expected %b", k, TICK[1:0], {(k % 6) == 0, (k % 3) == 0});
         end
         n_chk++;
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_fail++; $display("FAIL sync_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
   endtask

   task automatic test_extremes();
      EN = 3'b000;
      LOAD = 1'b1; LOAD_SEL = 2'd0; DIV_IN = 10'd0;
      @(negedge CLK_IN);
      LOAD_SEL = 2'd2; DIV_IN = 10'd1023;
      @(negedge CLK_IN);
      LOAD = 1'b0;
      @(negedge CLK_IN);
      EN = 3'b101;
      for (int k = 0; k < 1100; k++) begin
         @(negedge CLK_IN);
         if (k < 5) begin
            n_chk++;
            if (CLK_OUT[0] !== 1'b1 || TICK[0] !== 1'b1) begin
               n_fail++; $display("FAIL d0 k=%0d: clk %b tick %b expected 1/1", k, CLK_OUT[0], TICK[0]);
            end
         end
         if (k == 0 || k == 511 || k == 512 || k == 1022 || k == 1023) begin
            n_chk++;
            if (CLK_OUT[2] !== ((k % 1023) < 512) || TICK[2] !== ((k % 1023) == 0)) begin
               n_fail++; $display("FAIL d1023 k=%0d: clk %b tick %b", k, CLK_OUT[2], TICK[2]);
            end
         end
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_chk++; n_fail++;
            $display("FAIL extreme_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
      n_chk++;  // accounts for the per-cycle model sweep above
      // Asynchronous reset in the middle of a period.
      #2 RST = 1'b1;
      #1;
      n_chk++;
      if ({CLK_OUT, TICK, PENDING} !== '0) begin
         n_fail++; $display("FAIL async_reset: got %b expected 0", {CLK_OUT, TICK, PENDING});
      end
      @(negedge CLK_IN);
      EN = 3'b001;
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT !== {2'b00, (k % 2) == 0} || TICK !== {2'b00, (k % 2) == 0} || PENDING !== 3'b000) begin
            n_fail++; $display("FAIL post_reset k=%0d: clk %b tick %b pend %b", k, CLK_OUT, TICK, PENDING);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) == 0) EN = NCH'($urandom_range(0, 7));
         SYNC = ($urandom_range(0, 19) == 0);
         LOAD = ($urandom_range(0, 5) == 0);
         LOAD_SEL = SELW'($urandom_range(0, 3));
         DIV_IN = WIDTH'($urandom_range(0, 9));
         @(negedge CLK_IN);
         n_chk++;
         if (CLK_OUT !== m_clk || TICK !== m_tick || PENDING !== m_pend) begin
            n_fail++; $display("FAIL random k=%0d: got %b/%b/%b expected %b/%b/%b", k, CLK_OUT, TICK, PENDING, m_clk, m_tick, m_pend);
         end
      end
      SYNC = 1'b0; LOAD = 1'b0;
   endtask

   initial begin
      test_reset();
      test_div2();
      test_div5();
      test_reload();
      test_load_on_wrap();
      test_sync();
      test_extremes();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
